sort_frame_serializer: RTL and testbench

//  Output-side companion to the bitonic sorter. It captures each sorted frame (DEPTH parallel

---
 rtl/sort_frame_serializer.sv | 113 +++++++++++
 tb/tb_sort_frame_serializer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_frame_serializer.sv
// rtl/sort_frame_serializer.sv - ping-pong frame buffer streaming sorted frames one word per beat
module sort_frame_serializer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_valid,
    input  logic [WIDTH-1:0] frame_data [0:DEPTH-1],
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [IDX_W-1:0] m_index,
    output logic             m_last,
    output logic             busy,
    output logic             full,
    output logic             overflow,
    output logic [CNT_W-1:0] drop_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    occ_t             state, state_next;
    logic [WIDTH-1:0] slot [0:1][0:DEPTH-1];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [IDX_W-1:0] elem_idx;

    logic pop;
    logic pop_last;
    logic accept_in;
    logic drop;
    logic at_last;

    assign at_last   = (elem_idx == IDX_W'(DEPTH - 1));
    assign m_valid   = (state != EMPTY);
    assign pop       = m_valid && m_ready;
    assign pop_last  = pop && at_last;
    // A frame landing on the cycle the last word of a full buffer leaves reuses that slot.
    assign accept_in = frame_valid && ((state != FULL) || pop_last);
    assign drop      = frame_valid && (state == FULL) && !pop_last;

    assign m_data  = m_valid ? slot[rd_ptr][elem_idx] : '0;
    assign m_index = elem_idx;
    assign m_last  = m_valid && at_last;
    assign busy    = (state != EMPTY);
    assign full    = (state == FULL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: begin
                if (accept_in) state_next = ONE;
            end
            ONE: begin
                if (accept_in && !pop_last) state_next = FULL;
                else if (pop_last && !accept_in) state_next = EMPTY;
            end
            FULL: begin
                if (pop_last && !accept_in) state_next = ONE;
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            elem_idx <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            overflow <= drop;
            if (drop && (drop_cnt != {CNT_W{1'b1}})) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
            if (accept_in) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop_last) begin
                elem_idx <= '0;
                rd_ptr   <= ~rd_ptr;
            end else if (pop) begin
                elem_idx <= elem_idx + IDX_W'(1);
            end
        end
    end

    // Frame storage carries no reset; occupancy state alone decides what is visible.
    always_ff @(posedge clk) begin
        if (!rst && accept_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot[wr_ptr][i] <= frame_data[i];
            end
        end
    end

endmodule

// File: tb/tb_sort_frame_serializer.sv
// tb/tb_sort_frame_serializer.sv - directed self-checking bench for sort_frame_serializer
module tb_sort_frame_serializer;

    localparam int WIDTH = 32;
    localparam int DEPTH = 8;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst;
    logic             frame_valid;
    logic [WIDTH-1:0] frame_data [0:DEPTH-1];
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic [2:0]       m_index;
    logic             m_last;
    logic             busy;
    logic             full;
    logic             overflow;
    logic [CNT_W-1:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    sort_frame_serializer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .frame_valid(frame_valid), .frame_data(frame_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_index(m_index),
        .m_last(m_last), .busy(busy), .full(full), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_frame(input int base);
        for (int i = 0; i < DEPTH; i++) frame_data[i] = WIDTH'(base + i);
        frame_valid = 1'b1;
    endtask

    task automatic strobe(input int base);
        load_frame(base);
        tick();
        frame_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({m_valid, m_last, busy, full, overflow} !== 5'b0 || m_data !== 0 || m_index !== 0 || drop_cnt !== 0) begin
            errors++;
            $display("FAIL reset_state: valid=%b last=%b busy=%b full=%b ovf=%b data=%0d idx=%0d drop=%0d, need all 0",
                     m_valid, m_last, busy, full, overflow, m_data, m_index, drop_cnt);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_frame();
        m_ready = 1'b1;
        strobe(1);
        for (int k = 0; k < DEPTH; k++) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== WIDTH'(k + 1) || m_index !== 3'(k) || m_last !== (k == DEPTH - 1)) begin
                errors++;
                $display("FAIL single_beat%0d: valid=%b data=%0d idx=%0d last=%b, need 1 %0d %0d %b",
                         k, m_valid, m_data, m_index, m_last, k + 1, k, k == DEPTH - 1);
            end
            tick();
        end
        checks++;
        if (busy !== 1'b0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: busy=%b valid=%b, need 0 0", busy, m_valid);
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        logic prev_stall = 1'b0;
        logic [WIDTH-1:0] prev_data = '0;
        logic [2:0] prev_idx = '0;
        logic prev_last = 1'b0;
        m_ready = 1'b0;
        strobe(1);
        for (int c = 0; c < 60 && n < DEPTH; c++) begin
            if (prev_stall) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== prev_data || m_index !== prev_idx || m_last !== prev_last) begin
                    errors++;
                    $display("FAIL bp_stable c%0d: valid=%b data=%0d idx=%0d, need 1 %0d %0d",
                             c, m_valid, m_data, m_index, prev_data, prev_idx);
                end
            end
            m_ready = (c % 3 == 0);
            if (m_valid && m_ready) begin
                checks++;
                if (m_data !== WIDTH'(n + 1) || m_index !== 3'(n)) begin
                    errors++;
                    $display("FAIL bp_word%0d: data=%0d idx=%0d, need %0d %0d", n, m_data, m_index, n + 1, n);
                end
                n++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_idx   = m_index;
            prev_last  = m_last;
            tick();
        end
        checks++;
        if (n != DEPTH || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_count: words=%0d valid_after=%b, need %0d 0", n, m_valid, DEPTH);
        end
        m_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        int exp;
        m_ready = 1'b1;
        for (int c = 0; c < 18; c++) begin
            if (c >= 1 && c <= 16) begin
                exp = (c <= 8) ? 10 + (c - 1) : 20 + (c - 9);
                checks++;
                if (m_valid !== 1'b1 || m_data !== WIDTH'(exp) || m_last !== (c == 8 || c == 16)) begin
                    errors++;
                    $display("FAIL b2b_c%0d: valid=%b data=%0d last=%b, need 1 %0d %b",
                             c, m_valid, m_data, m_last, exp, c == 8 || c == 16);
                end
            end else if (c == 17) begin
                checks++;
                if (m_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_idle: valid=%b, need 0", m_valid);
                end
            end
            if (c == 0) load_frame(10);
            else if (c == 2) load_frame(20);
            else frame_valid = 1'b0;
            tick();
        end
    endtask

    task automatic test_overflow();
        int exp;
        m_ready = 1'b0;
        strobe(10);
        strobe(20);
        checks++;
        if (full !== 1'b1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_full: full=%b ovf=%b, need 1 0", full, overflow);
        end
        strobe(30);
        checks++;
        if (overflow !== 1'b1 || drop_cnt !== 16'd1) begin
            errors++;
            $display("FAIL ovf_pulse: ovf=%b drop=%0d, need 1 1", overflow, drop_cnt);
        end
        tick();
        checks++;
        if (overflow !== 1'b0 || drop_cnt !== 16'd1) begin
            errors++;
            $display("FAIL ovf_clear: ovf=%b drop=%0d, need 0 1", overflow, drop_cnt);
        end
        m_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            exp = (k < 8) ? 10 + k : 20 + (k - 8);
            checks++;
            if (m_valid !== 1'b1 || m_data !== WIDTH'(exp)) begin
                errors++;
                $display("FAIL ovf_beat%0d: valid=%b data=%0d, need 1 %0d", k, m_valid, m_data, exp);
            end
            tick();
        end
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovf_no_c: valid=%b data=%0d, need valid 0", m_valid, m_data);
        end
    endtask

    task automatic test_full_reuse();
        int exp;
        m_ready = 1'b0;
        strobe(10);
        strobe(20);
        m_ready = 1'b1;
        for (int k = 0; k < 24; k++) begin
            exp = (k < 8) ? 10 + k : (k < 16) ? 20 + (k - 8) : 30 + (k - 16);
            checks++;
            if (m_valid !== 1'b1 || m_data !== WIDTH'(exp)) begin
                errors++;
                $display("FAIL reuse_beat%0d: valid=%b data=%0d, need 1 %0d", k, m_valid, m_data, exp);
            end
            if (k == 7) load_frame(30);
            else frame_valid = 1'b0;
            tick();
            if (k == 7) begin
                checks++;
                if (overflow !== 1'b0 || full !== 1'b1 || drop_cnt !== 16'd1) begin
                    errors++;
                    $display("FAIL reuse_no_drop: ovf=%b full=%b drop=%0d, need 0 1 1", overflow, full, drop_cnt);
                end
            end
        end
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL reuse_idle: valid=%b, need 0", m_valid);
        end
    endtask

    task automatic test_reset_mid_frame();
        m_ready = 1'b1;
        strobe(40);
        tick();
        tick();
        tick();
        checks++;
        if (m_index !== 3'd3 || m_data !== 43) begin
            errors++;
            $display("FAIL rstmid_beat3: idx=%0d data=%0d, need 3 43", m_index, m_data);
        end
        rst = 1'b1;
        load_frame(60);
        tick();
        rst = 1'b0;
        frame_valid = 1'b0;
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || drop_cnt !== 0 || m_data !== 0) begin
            errors++;
            $display("FAIL rstmid_clear: valid=%b busy=%b drop=%0d data=%0d, need 0 0 0 0",
                     m_valid, busy, drop_cnt, m_data);
        end
        tick();
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_frame_discard: valid=%b, need 0", m_valid);
        end
        strobe(50);
        for (int k = 0; k < DEPTH; k++) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== WIDTH'(50 + k) || m_index !== 3'(k)) begin
                errors++;
                $display("FAIL rstmid_fresh%0d: valid=%b data=%0d idx=%0d, need 1 %0d %0d",
                         k, m_valid, m_data, m_index, 50 + k, k);
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        frame_valid = 1'b0;
        m_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) frame_data[i] = '0;
        test_reset();
        test_single_frame();
        test_backpressure();
        test_back_to_back();
        test_overflow();
        test_full_reuse();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
